dm_responder: RTL

- Multi-cycle data-memory responder: the memory-side end of the CPU's load/store interface. It accepts one load or store request through a valid/ready handshake, inserts programmable wait states, then returns a response through a second valid/ready handshake.
- Replaces the combinational data memory when the core moves to a multi-cycle or pipelined datapath.
- Word-addressed storage, byte addresses on the interface, one outstanding transaction.

---
 rtl/dm_pkg.sv | 21 ++
 rtl/dm_storage_array.sv | 33 +++
 rtl/dm_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared types and constants for the data-memory responder.
//   dm_state_e  : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES  : bytes per stored word
//   ADDR_LSB    : lowest byte-address bit that selects a word
//   idx_width() : word-index width for a given depth
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dm_storage_array.sv
// dm_storage_array: single-port 32-bit synchronous RAM, no reset.
// Ports:
//   i_clk   : clock, rising edge
//   i_we    : write i_wdata into word i_idx
//   i_re    : register word i_idx onto o_rdata
//   i_idx   : word index
//   i_wdata : write data
//   o_rdata : registered read data, holds until the next i_re
module dm_storage_array
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IW         = idx_width(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [IW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata      <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory responder, one outstanding request.
// A request is accepted in IDLE, waits WAIT_CYCLES states, commits on the
// edge entering RESP, and is held in RESP until the requester takes it.
// Optional feature macro: DM_ERR_EN (misaligned / out-of-range faults).
// Ports:
//   i_clk, i_rst_n    : clock, async active-low reset
//   i_req_valid/o_req_ready : request handshake
//   i_req_write       : 1 = store, 0 = load
//   i_req_addr        : byte address
//   i_req_wdata       : store data
//   o_resp_valid/i_resp_ready : response handshake
//   o_resp_rdata      : load data, 0 for stores and faults
//   o_resp_err        : request faulted (0 unless DM_ERR_EN)
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  localparam int IW = idx_width(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dm_state_e     r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_write;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_err;

  logic          w_accept, w_commit;
  logic [IW-1:0] w_in_idx, w_c_idx;
  logic          w_in_err, w_c_err, w_c_write;
  logic [31:0]   w_c_wdata, w_ram_q;

  assign w_in_idx = i_req_addr[IW+ADDR_LSB-1:ADDR_LSB];

`ifdef DM_ERR_EN
  assign w_in_err = (i_req_addr[ADDR_LSB-1:0] != '0) ||
                    ((i_req_addr >> (IW + ADDR_LSB)) != 32'd0);
`else
  // Sub-word and above-range address bits are dropped: addresses wrap.
  logic w_unused;
  assign w_in_err = 1'b0;
  assign w_unused = ^{i_req_addr[31:IW+ADDR_LSB], i_req_addr[ADDR_LSB-1:0]};
`endif

  assign w_accept = i_req_valid && (r_state == IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        if (WAIT_CYCLES == 0) begin
          w_state_nxt = RESP;
          w_commit    = 1'b1;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: if (r_cnt == 4'd0) begin
        w_state_nxt = RESP;
        w_commit    = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
      RESP: if (i_resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so the
  // request fields come straight from the inputs rather than the latches.
  assign w_c_write = (r_state == IDLE) ? i_req_write : r_write;
  assign w_c_idx   = (r_state == IDLE) ? w_in_idx    : r_idx;
  assign w_c_wdata = (r_state == IDLE) ? i_req_wdata : r_wdata;
  assign w_c_err   = (r_state == IDLE) ? w_in_err    : r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= i_req_write;
        r_idx   <= w_in_idx;
        r_wdata <= i_req_wdata;
        r_err   <= w_in_err;
      end
    end
  end

  dm_storage_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_commit && w_c_write && !w_c_err),
    .i_re    (w_commit && !w_c_write),
    .i_idx   (w_c_idx),
    .i_wdata (w_c_wdata),
    .o_rdata (w_ram_q)
  );

  // The RAM read register only changes at a load commit, so it stays
  // stable for the whole RESP state; outside RESP the data is forced to 0.
  assign o_req_ready  = (r_state == IDLE);
  assign o_resp_valid = (r_state == RESP);
  assign o_resp_err   = (r_state == RESP) && r_err;
  assign o_resp_rdata = ((r_state == RESP) && !r_write && !r_err) ? w_ram_q : 32'd0;

endmodule
